// File: rtl/crank_gen_pkg.sv
// Shared constants and state type for the crank tooth-wheel generator.
package crank_gen_pkg;
  localparam int TEETH_DEF  = 60;
  localparam int GAP_DEF    = 2;
  localparam int PWIDTH_DEF = 24;
  localparam int PMIN       = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } crank_state_e;
endpackage

// File: rtl/crank_slot_timer.sv
// Per-slot cycle counter: counts 0..P-1 and reloads P from the shadow value
// only at a slot boundary (or on start), so period changes never cut a slot.
module crank_slot_timer
  import crank_gen_pkg::*;
#(
  parameter int PWIDTH = PWIDTH_DEF
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              srst,
  input  logic              start,
  input  logic              adv,
  input  logic [PWIDTH-1:0] shadow,
  output logic [PWIDTH-1:0] cnt_next,
  output logic [PWIDTH-1:0] p_next,
  output logic              slot_end
);
  logic [PWIDTH-1:0] cnt_q, cnt_d;
  logic [PWIDTH-1:0] p_q, p_d;
  logic [PWIDTH-1:0] shadow_c;

  // Shadow resets to 0, so the reload path clamps as well.
  assign shadow_c = (shadow < PWIDTH'(PMIN)) ? PWIDTH'(PMIN) : shadow;

  always_comb begin
    cnt_d    = cnt_q;
    p_d      = p_q;
    slot_end = adv && (cnt_q == p_q - PWIDTH'(1));
    if (start) begin
      cnt_d = '0;
      p_d   = shadow_c;
    end else if (slot_end) begin
      cnt_d = '0;
      p_d   = shadow_c;
    end else if (adv) begin
      cnt_d = cnt_q + PWIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
      p_q   <= PWIDTH'(PMIN);
    end else if (srst) begin
      cnt_q <= '0;
      p_q   <= PWIDTH'(PMIN);
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  assign cnt_next = cnt_d;
  assign p_next   = p_d;
endmodule

// File: rtl/crank_tooth_gen.sv
// Synthetic TEETH-minus-GAP crank wheel: slot counter, shadow period,
// IDLE/RUN control and registered tooth/sync decode from next state.
module crank_tooth_gen
  import crank_gen_pkg::*;
#(
  parameter int TEETH  = TEETH_DEF,
  parameter int GAP    = GAP_DEF,
  parameter int PWIDTH = PWIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     srst,
  input  logic                     ena,
  input  logic [PWIDTH-1:0]        period,
  input  logic                     period_load,
  output logic                     tooth_out,
  output logic [$clog2(TEETH)-1:0] tooth_num,
  output logic                     sync,
  output logic                     running
);
  localparam int SW = $clog2(TEETH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(TEETH - 1);
  localparam logic [SW-1:0] FIRST_GAP = SW'(TEETH - GAP);

  crank_state_e      state_q, state_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic [PWIDTH-1:0] s_q, s_d;
  logic              tooth_q, tooth_d;
  logic              sync_q, sync_d;

  logic              start, adv, slot_end;
  logic [PWIDTH-1:0] cnt_next, p_next;

  assign start = (state_q == IDLE) && ena;
  assign adv   = (state_q == RUN) && ena;

  crank_slot_timer #(.PWIDTH(PWIDTH)) u_timer (
    .clk      (clk),
    .arst     (arst),
    .srst     (srst),
    .start    (start),
    .adv      (adv),
    .shadow   (s_q),
    .cnt_next (cnt_next),
    .p_next   (p_next),
    .slot_end (slot_end)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    s_d     = s_q;
    tooth_d = tooth_q;
    sync_d  = sync_q;
    if (period_load) begin
      s_d = (period < PWIDTH'(PMIN)) ? PWIDTH'(PMIN) : period;
    end
    if (start) begin
      state_d = RUN;
      slot_d  = '0;
    end else if (slot_end) begin
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SW'(1);
    end
    // Outputs only move on enabled edges, so a raised sync holds while ena is low.
    if (start || adv) begin
      tooth_d = (slot_d < FIRST_GAP) && (cnt_next < (p_next >> 1));
      sync_d  = (slot_d == '0) && (cnt_next == '0);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      s_q     <= '0;
      tooth_q <= 1'b0;
      sync_q  <= 1'b0;
    end else if (srst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      s_q     <= '0;
      tooth_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      s_q     <= s_d;
      tooth_q <= tooth_d;
      sync_q  <= sync_d;
    end
  end

  assign tooth_out = tooth_q;
  assign tooth_num = slot_q;
  assign sync      = sync_q;
  assign running   = (state_q == RUN);
endmodule

// File: doc/crank_tooth_gen.md
# crank_tooth_gen

Synthetic crankshaft tooth-wheel signal generator: produces a TEETH-minus-GAP pattern (default 60-2) with a programmable tooth period, plus tooth index and once-per-revolution sync. It is the transmitter end of the crank-sensor input that the angle generator decodes. It drives bench and loopback stimulus and can replace the physical sensor in on-board self-test.

## Interface
- TEETH, 60, tooth slots per revolution, including missing ones.
- GAP, 2, missing slots at the end of the revolution (slots TEETH-GAP..TEETH-1).
- PWIDTH, 24, width of the tooth-period value in clk cycles.
- clk  in  1  clock.
- arst  in  1  reset, asynchronous, active-high.
- srst  in  1  synchronous reset, active-high; same effect as arst on the next clk edge.
- ena  in  1  advance enable; when low, all state and outputs hold.
- period  in  PWIDTH  requested slot period in clk cycles.
- period_load  in  1  strobe: capture period into the shadow register.
- tooth_out  out  1  generated sensor signal.
- tooth_num  out  $clog2(TEETH)  current slot index, 0..TEETH-1.
- sync  out  1  one-cycle pulse on the first cycle of slot 0.
- running  out  1  generator started.

## Operation
- Registers: shadow period S, active period P, slot counter, cycle counter cnt (0..P-1), running.
- Reset (arst or srst) values: S=0, P=2, slot=0, cnt=0, running=0, tooth_out=0, sync=0, tooth_num=0.
- period_load=1 sets S<=period on that edge regardless of ena. Loads are clamped: a value below 2 is stored as 2.
- States: IDLE (running=0) and RUN (running=1).
- IDLE -> RUN on the first edge with ena=1:
  - P<=S, slot=0, cnt=0.
  - tooth_out=1 if P>=2, sync=1.
- RUN, each edge with ena=1: cnt advances. At cnt=P-1 the slot ends: cnt<=0 and slot<=slot+1, with wrap from TEETH-1 to 0. P<=S at every slot boundary, never mid-slot.
- tooth_out is registered from next state: 1 when the next slot is a real tooth (slot < TEETH-GAP) and next cnt < P>>1; otherwise 0.
  - P=2 gives high 1 / low 1. P=3 gives high 1 / low 2.
  - Gap slots are low for the whole slot.
- sync is registered: 1 exactly in the cycle where slot=0 and cnt=0; otherwise 0.
- tooth_num always equals the registered slot.
- ena=0 freezes everything, including an asserted sync, which stays high until the next enabled edge.
- srst has priority over ena and period_load. arst has priority over everything.

## Timing
- Latency from ena high in IDLE to tooth_out/sync high: 1 edge.
- Revolution length: TEETH×P cycles with a constant P.
- A period change requested mid-slot takes effect from the next slot boundary. If period_load coincides with the boundary edge, the newly loaded value is not used; the slot after that uses it.
- Simultaneous wrap and sync: sync asserts in the cycle after the edge taking slot TEETH-1 to 0.
- Reset mid-revolution: all outputs return to reset values immediately (arst) or on the next edge (srst). Restart begins at slot 0.

## Structure
- Package crank_gen_pkg: default TEETH, GAP, PWIDTH; minimum period constant PMIN=2; the IDLE/RUN state enum.
- Sub-module crank_slot_timer holds cnt, P-reload at the boundary, and the end-of-slot strobe.
- Top level holds slot/tooth counter, output decode, shadow register, IDLE/RUN control.
- Total RTL 150-250 lines.

## Test plan
- Load period=4, ena=1:
  - tooth_out repeats 1100 for 58 slots, then 8 low cycles.
  - sync high once every 240 cycles.
  - tooth_num 0..59 wraps.
- period=0 loaded: behaves as P=2. tooth_out alternates 1,0; the gap is 4 low cycles; revolution is 120 cycles.
- Running at P=4, load 6 at cnt=1 of slot 10: slot 10 stays 4 cycles, slot 11 is 6 cycles with tooth_out 111000.
- ena low for 5 cycles mid-tooth: tooth_out, tooth_num and cnt are held; on resume the sequence continues with no lost or extra cycles.
- srst pulse at slot 30, then arst pulse in the gap: every output reads 0 the next cycle. Restart yields sync on the first enabled edge.
- TEETH=36, GAP=1, P=3: 35 teeth of 100, then 3 low cycles; revolution is 108 cycles.
